// File: rtl/sync_fifo.sv
// Synchronous FIFO with power-of-two width conversion, FWFT or standard read mode,
// registered occupancy counts/flags and single-cycle status strobes.
module sync_fifo #(
  parameter int          INPUT_WIDTH       = 16,
  parameter int          OUTPUT_WIDTH      = 16,
  parameter int          WR_DEPTH          = 16,
  parameter int          RD_DEPTH          = 16,
  parameter string       MODE              = "FWFT",
  parameter string       DIRECTION         = "MSB",
  parameter string       ECC_MODE          = "no_ecc",
  parameter int          PROG_EMPTY_THRESH = 10,
  parameter int          PROG_FULL_THRESH  = 10,
  parameter logic [15:0] USE_ADV_FEATURES  = 16'h1F1F
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [INPUT_WIDTH-1:0]        din,
  input  logic                          rd_en,
  output logic [OUTPUT_WIDTH-1:0]       dout,
  output logic                          valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic                          prog_full,
  output logic                          prog_empty,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          wr_ack,
  output logic                          sbiterr,
  output logic                          dbiterr,
  output logic [$clog2(WR_DEPTH):0]     wr_data_count,
  output logic [$clog2(WR_DEPTH):0]     wr_data_space,
  output logic [$clog2(RD_DEPTH):0]     rd_data_count,
  output logic [$clog2(RD_DEPTH):0]     rd_data_space
);

  localparam int NW       = (INPUT_WIDTH < OUTPUT_WIDTH) ? INPUT_WIDTH : OUTPUT_WIDTH;
  localparam int WR_RATIO = INPUT_WIDTH / NW;
  localparam int RD_RATIO = OUTPUT_WIDTH / NW;
  localparam int DEPTH_N  = WR_DEPTH * WR_RATIO;
  localparam int PW       = $clog2(DEPTH_N);
  localparam int NCW      = $clog2(DEPTH_N) + 1;
  localparam int WCW      = $clog2(WR_DEPTH) + 1;
  localparam int RCW      = $clog2(RD_DEPTH) + 1;
  localparam bit IS_FWFT   = (MODE == "FWFT");
  localparam bit MSB_FIRST = (DIRECTION == "MSB");
  localparam bit ECC_NONE  = (ECC_MODE == "no_ecc");

  logic [NW-1:0]           mem [DEPTH_N];
  logic [PW-1:0]           wptr_r, rptr_r;
  logic [NCW-1:0]          nfill_r, nfill_next_s;
  logic [WCW-1:0]          wcnt_r;
  logic [RCW-1:0]          rcnt_r;
  int                      wcnt_next_s, rcnt_next_s;
  logic                    full_r, afull_r, pfull_r, empty_r, aempty_r, pempty_r;
  logic                    wr_ack_r, ovf_r, unf_r, std_valid_r;
  logic [OUTPUT_WIDTH-1:0] std_dout_r, head_s;
  logic                    wr_acc_s, rd_acc_s;

  function automatic logic [PW-1:0] ptr_adv(input logic [PW-1:0] p, input int step);
    if (int'(p) + step >= DEPTH_N) begin
      return PW'(int'(p) + step - DEPTH_N);
    end else begin
      return PW'(int'(p) + step);
    end
  endfunction

  assign wr_acc_s = wr_en & ~full_r;
  assign rd_acc_s = rd_en & ~empty_r;

  // Occupancy is tracked in narrow units; a partly filled wide slot still blocks a write
  // (ceiling) but is not yet readable (floor).
  always_comb begin
    nfill_next_s = nfill_r + (wr_acc_s ? NCW'(WR_RATIO) : NCW'(0))
                           - (rd_acc_s ? NCW'(RD_RATIO) : NCW'(0));
    wcnt_next_s  = (int'(nfill_next_s) + WR_RATIO - 1) / WR_RATIO;
    rcnt_next_s  = int'(nfill_next_s) / RD_RATIO;
  end

  always_comb begin
    head_s = '0;
    for (int i = 0; i < RD_RATIO; i++) begin
      if (MSB_FIRST) begin
        head_s[(RD_RATIO-1-i)*NW +: NW] = mem[PW'(int'(rptr_r) + i)];
      end else begin
        head_s[i*NW +: NW] = mem[PW'(int'(rptr_r) + i)];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && wr_acc_s) begin
      for (int i = 0; i < WR_RATIO; i++) begin
        mem[PW'(int'(wptr_r) + i)] <= MSB_FIRST ? din[(WR_RATIO-1-i)*NW +: NW] : din[i*NW +: NW];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_r      <= '0;
      rptr_r      <= '0;
      nfill_r     <= '0;
      wcnt_r      <= '0;
      rcnt_r      <= '0;
      full_r      <= 1'b0;
      afull_r     <= 1'b0;
      pfull_r     <= 1'b0;
      empty_r     <= 1'b1;
      aempty_r    <= 1'b0;
      pempty_r    <= 1'b1;
      wr_ack_r    <= 1'b0;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
      std_valid_r <= 1'b0;
      std_dout_r  <= '0;
    end else begin
      if (wr_acc_s) wptr_r <= ptr_adv(wptr_r, WR_RATIO);
      if (rd_acc_s) rptr_r <= ptr_adv(rptr_r, RD_RATIO);
      nfill_r     <= nfill_next_s;
      wcnt_r      <= WCW'(wcnt_next_s);
      rcnt_r      <= RCW'(rcnt_next_s);
      full_r      <= (wcnt_next_s == WR_DEPTH);
      afull_r     <= (wcnt_next_s == WR_DEPTH - 1);
      pfull_r     <= (wcnt_next_s >= PROG_FULL_THRESH);
      empty_r     <= (rcnt_next_s == 0);
      aempty_r    <= (rcnt_next_s == 1);
      pempty_r    <= (rcnt_next_s <= PROG_EMPTY_THRESH);
      wr_ack_r    <= wr_acc_s;
      ovf_r       <= wr_en & full_r;
      unf_r       <= rd_en & empty_r;
      std_valid_r <= rd_acc_s;
      if (rd_acc_s) std_dout_r <= head_s;
    end
  end

  // FWFT shows the head straight from storage; standard mode shows the last popped word.
  assign dout          = IS_FWFT ? (empty_r ? '0 : head_s) : std_dout_r;
  assign valid         = USE_ADV_FEATURES[12] & (IS_FWFT ? ~empty_r : std_valid_r);
  assign full          = full_r;
  assign empty         = empty_r;
  assign almost_full   = USE_ADV_FEATURES[3]  & afull_r;
  assign almost_empty  = USE_ADV_FEATURES[11] & aempty_r;
  assign prog_full     = USE_ADV_FEATURES[1]  & pfull_r;
  assign prog_empty    = USE_ADV_FEATURES[9]  & pempty_r;
  assign overflow      = USE_ADV_FEATURES[0]  & ovf_r;
  assign underflow     = USE_ADV_FEATURES[8]  & unf_r;
  assign wr_ack        = USE_ADV_FEATURES[4]  & wr_ack_r;
  assign wr_data_count = USE_ADV_FEATURES[2]  ? wcnt_r : '0;
  assign rd_data_count = USE_ADV_FEATURES[10] ? rcnt_r : '0;
  assign wr_data_space = WCW'(WR_DEPTH) - wcnt_r;
  assign rd_data_space = RCW'(RD_DEPTH) - rcnt_r;
  // There is no ECC datapath, so error flags stay low whatever ECC_MODE says.
  assign sbiterr       = ~ECC_NONE & 1'b0;
  assign dbiterr       = ~ECC_NONE & 1'b0;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: queue model checked every cycle on a 16/16 FWFT instance, plus
// directed literal checks on standard-mode and width-converting instances.
module tb_sync_fifo;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        a_wr = 1'b0, a_rd = 1'b0;
  logic [15:0] a_din = 16'h0000;
  logic [7:0]  n_din = 8'h00;

  wire [15:0] dout;
  wire        valid, full, empty, afull, aempty, pfull, pempty, ovf, unf, ack, sbe, dbe;
  wire [4:0]  wcnt, wsp, rcnt, rsp;

  wire [3:0]  x_full, x_empty, x_af, x_ae, x_pf, x_pe, x_ov, x_un, x_ack, x_sb, x_db, x_valid;
  wire [15:0] s_dout, n_dout;
  wire [7:0]  m_dout, l_dout;
  wire [4:0]  s_wcnt, s_wsp, s_rcnt, s_rsp, m_wcnt, m_wsp, l_wcnt, l_wsp, n_rcnt, n_rsp;
  wire [5:0]  m_rcnt, m_rsp, l_rcnt, l_rsp, n_wcnt, n_wsp;

  sync_fifo u_dut (.clock(clk), .reset(reset), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .valid(valid), .full(full), .empty(empty), .almost_full(afull),
    .almost_empty(aempty), .prog_full(pfull), .prog_empty(pempty), .overflow(ovf),
    .underflow(unf), .wr_ack(ack), .sbiterr(sbe), .dbiterr(dbe), .wr_data_count(wcnt),
    .wr_data_space(wsp), .rd_data_count(rcnt), .rd_data_space(rsp));

  sync_fifo #(.MODE("STANDARD")) u_std (.clock(clk), .reset(reset), .wr_en(a_wr), .din(a_din),
    .rd_en(a_rd), .dout(s_dout), .valid(x_valid[0]), .full(x_full[0]), .empty(x_empty[0]),
    .almost_full(x_af[0]), .almost_empty(x_ae[0]), .prog_full(x_pf[0]), .prog_empty(x_pe[0]),
    .overflow(x_ov[0]), .underflow(x_un[0]), .wr_ack(x_ack[0]), .sbiterr(x_sb[0]),
    .dbiterr(x_db[0]), .wr_data_count(s_wcnt), .wr_data_space(s_wsp), .rd_data_count(s_rcnt),
    .rd_data_space(s_rsp));

  sync_fifo #(.OUTPUT_WIDTH(8), .RD_DEPTH(32), .DIRECTION("MSB")) u_msb (.clock(clk),
    .reset(reset), .wr_en(a_wr), .din(a_din), .rd_en(a_rd), .dout(m_dout), .valid(x_valid[1]),
    .full(x_full[1]), .empty(x_empty[1]), .almost_full(x_af[1]), .almost_empty(x_ae[1]),
    .prog_full(x_pf[1]), .prog_empty(x_pe[1]), .overflow(x_ov[1]), .underflow(x_un[1]),
    .wr_ack(x_ack[1]), .sbiterr(x_sb[1]), .dbiterr(x_db[1]), .wr_data_count(m_wcnt),
    .wr_data_space(m_wsp), .rd_data_count(m_rcnt), .rd_data_space(m_rsp));

  sync_fifo #(.OUTPUT_WIDTH(8), .RD_DEPTH(32), .DIRECTION("LSB")) u_lsb (.clock(clk),
    .reset(reset), .wr_en(a_wr), .din(a_din), .rd_en(a_rd), .dout(l_dout), .valid(x_valid[2]),
    .full(x_full[2]), .empty(x_empty[2]), .almost_full(x_af[2]), .almost_empty(x_ae[2]),
    .prog_full(x_pf[2]), .prog_empty(x_pe[2]), .overflow(x_ov[2]), .underflow(x_un[2]),
    .wr_ack(x_ack[2]), .sbiterr(x_sb[2]), .dbiterr(x_db[2]), .wr_data_count(l_wcnt),
    .wr_data_space(l_wsp), .rd_data_count(l_rcnt), .rd_data_space(l_rsp));

  sync_fifo #(.INPUT_WIDTH(8), .WR_DEPTH(32), .DIRECTION("MSB")) u_n2w (.clock(clk),
    .reset(reset), .wr_en(a_wr), .din(n_din), .rd_en(a_rd), .dout(n_dout), .valid(x_valid[3]),
    .full(x_full[3]), .empty(x_empty[3]), .almost_full(x_af[3]), .almost_empty(x_ae[3]),
    .prog_full(x_pf[3]), .prog_empty(x_pe[3]), .overflow(x_ov[3]), .underflow(x_un[3]),
    .wr_ack(x_ack[3]), .sbiterr(x_sb[3]), .dbiterr(x_db[3]), .wr_data_count(n_wcnt),
    .wr_data_space(n_wsp), .rd_data_count(n_rcnt), .rd_data_space(n_rsp));

  int n_checks = 0;
  int n_errors = 0;
  bit run_cmp  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an ordered list of stored words plus the strobes owed next cycle.
  logic [15:0] q[$];
  logic        e_ack = 1'b0, e_ovf = 1'b0, e_unf = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      e_ack <= 1'b0;
      e_ovf <= 1'b0;
      e_unf <= 1'b0;
    end else begin
      e_ack <= wr_en && q.size() < 16;
      e_ovf <= wr_en && q.size() == 16;
      e_unf <= rd_en && q.size() == 0;
      if (wr_en && q.size() < 16) begin
        if (rd_en && q.size() != 0) void'(q.pop_front());
        q.push_back(din);
      end else if (rd_en && q.size() != 0) begin
        void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("wr_data_count", 32'(wcnt), 32'(q.size()));
      chk("rd_data_count", 32'(rcnt), 32'(q.size()));
      chk("wr_data_space", 32'(wsp), 32'(16 - q.size()));
      chk("rd_data_space", 32'(rsp), 32'(16 - q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == 16));
      chk("almost_full", 32'(afull), 32'(q.size() == 15));
      chk("almost_empty", 32'(aempty), 32'(q.size() == 1));
      chk("prog_full", 32'(pfull), 32'(q.size() >= 10));
      chk("prog_empty", 32'(pempty), 32'(q.size() <= 10));
      chk("valid", 32'(valid), 32'(q.size() != 0));
      chk("dout", 32'(dout), (q.size() != 0) ? 32'(q[0]) : 32'd0);
      chk("wr_ack", 32'(ack), 32'(e_ack));
      chk("overflow", 32'(ovf), 32'(e_ovf));
      chk("underflow", 32'(unf), 32'(e_unf));
      chk("ecc_flags", 32'({sbe, dbe}), 32'd0);
    end
  end

  initial begin
    tick();
    tick();
    reset = 1'b0;
    run_cmp = 1'b1;
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_space", 32'(wsp), 32'd16);
    chk("reset_prog_empty", 32'(pempty), 32'd1);
    chk("reset_dout", 32'(dout), 32'd0);

    // Fill with 0x0123 + k*0x0101, watching prog_full cross at ten words.
    for (int k = 0; k < 16; k++) begin
      wr_en = 1'b1;
      din = 16'h0123 + 16'(k) * 16'h0101;
      tick();
      if (k == 8) chk("prog_full_at_9", 32'(pfull), 32'd0);
      if (k == 9) chk("prog_full_at_10", 32'(pfull), 32'd1);
    end
    wr_en = 1'b0;
    chk("full_after_16", 32'(full), 32'd1);
    chk("count_after_16", 32'(wcnt), 32'd16);

    wr_en = 1'b1;
    din = 16'hDEAD;
    tick();
    wr_en = 1'b0;
    chk("overflow_pulse", 32'(ovf), 32'd1);
    tick();
    chk("overflow_clears", 32'(ovf), 32'd0);

    for (int k = 0; k < 16; k++) begin
      chk("fwft_read_order", 32'(dout), 32'h0123 + 32'(k) * 32'h0101);
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    chk("empty_after_drain", 32'(empty), 32'd1);
    chk("count_after_drain", 32'(rcnt), 32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("underflow_pulse", 32'(unf), 32'd1);
    tick();

    // Streaming: prefill five, then read and write every cycle.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      din = 16'h1000 + 16'(i);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      chk("stream_head", 32'(dout), 32'h1000 + 32'(i));
      wr_en = 1'b1;
      rd_en = 1'b1;
      din = 16'h1005 + 16'(i);
      tick();
      chk("stream_count", 32'(wcnt), 32'd5);
      chk("stream_wr_ack", 32'(ack), 32'd1);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rd_en = 1'b0;
    chk("stream_drained", 32'(empty), 32'd1);

    // Reset with eight words stored and traffic presented in the reset cycle.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      din = 16'h2000 + 16'(i);
      tick();
    end
    reset = 1'b1;
    din = 16'h7777;
    rd_en = 1'b1;
    tick();
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("midreset_count", 32'(wcnt), 32'd0);
    chk("midreset_empty", 32'(empty), 32'd1);
    chk("midreset_valid", 32'(valid), 32'd0);
    chk("midreset_dout", 32'(dout), 32'd0);
    chk("midreset_no_ack", 32'(ack), 32'd0);
    wr_en = 1'b1;
    din = 16'hBEEF;
    tick();
    din = 16'hCAFE;
    tick();
    wr_en = 1'b0;
    chk("post_reset_first", 32'(dout), 32'hBEEF);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("post_reset_second", 32'(dout), 32'hCAFE);

    // Standard mode and width conversion share one stimulus stream.
    a_wr = 1'b1;
    a_din = 16'h0123;
    n_din = 8'h01;
    tick();
    chk("n2w_half_rcount", 32'(n_rcnt), 32'd0);
    chk("n2w_half_empty", 32'(x_empty[3]), 32'd1);
    chk("n2w_half_wcount", 32'(n_wcnt), 32'd1);
    chk("w2n_rcount", 32'(m_rcnt), 32'd2);
    chk("w2n_wcount", 32'(m_wcnt), 32'd1);
    chk("w2n_msb_first", 32'(m_dout), 32'h01);
    chk("w2n_lsb_first", 32'(l_dout), 32'h23);
    a_din = 16'h4567;
    n_din = 8'h23;
    tick();
    a_wr = 1'b0;
    chk("n2w_word", 32'(n_dout), 32'h0123);
    chk("n2w_rcount", 32'(n_rcnt), 32'd1);
    chk("std_count", 32'(s_rcnt), 32'd2);
    chk("std_idle_valid", 32'(x_valid[0]), 32'd0);
    chk("std_idle_dout", 32'(s_dout), 32'd0);
    a_rd = 1'b1;
    tick();
    chk("w2n_msb_second", 32'(m_dout), 32'h23);
    chk("w2n_lsb_second", 32'(l_dout), 32'h01);
    chk("w2n_rcount_after_read", 32'(m_rcnt), 32'd3);
    chk("std_valid_pulse", 32'(x_valid[0]), 32'd1);
    chk("std_dout_first", 32'(s_dout), 32'h0123);
    chk("n2w_empty_after_read", 32'(x_empty[3]), 32'd1);
    tick();
    a_rd = 1'b0;
    chk("w2n_msb_third", 32'(m_dout), 32'h45);
    chk("w2n_lsb_third", 32'(l_dout), 32'h67);
    chk("std_valid_second", 32'(x_valid[0]), 32'd1);
    chk("std_dout_second", 32'(s_dout), 32'h4567);
    tick();
    chk("std_valid_drops", 32'(x_valid[0]), 32'd0);
    chk("std_dout_holds", 32'(s_dout), 32'h4567);
    chk("aux_ecc_flags", 32'({x_sb, x_db}), 32'd0);

    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
